// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback widths, register-file entry payload and arbiter state type.
package writeback_arbiter_pkg;

    localparam int unsigned WB_DATA_WIDTH_POW = 6;
    localparam int unsigned WB_DATA_WIDTH     = 1 << WB_DATA_WIDTH_POW;
    localparam int unsigned WB_RD_WIDTH       = 5;
    localparam int unsigned WB_FIFO_DEPTH_POW = 1;

    // One register-file write: destination index plus result
    typedef struct packed {
        logic [WB_RD_WIDTH-1:0]   rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Round-robin pointer: source that wins when both heads are valid
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_src_e;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: per-source result buffer, 2^DEPTH_POW entries, extra pointer bit for full/empty.
module wb_fifo #(
    parameter int unsigned DEPTH_POW = 1,
    parameter int unsigned WIDTH     = 69
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic             full_c,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_POW;
    localparam int unsigned PTR_W = DEPTH_POW + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_c  = (wr_ptr[DEPTH_POW] != rd_ptr[DEPTH_POW]) &&
                     (wr_ptr[DEPTH_POW-1:0] == rd_ptr[DEPTH_POW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign head_c  = mem[rd_ptr[DEPTH_POW-1:0]];
    assign do_push = push_in && !full_c && !flush_in;
    assign do_pop  = pop_in && !empty_c && !flush_in;

    // Pointer update; reset and flush both empty the buffer
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[DEPTH_POW-1:0]] <= push_data_in;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results and drains one per cycle
// into the register-file write port, round-robin between sources.
// Optional WB_BYPASS_EN adds two combinational forwarding compare ports.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned REG_DATA_WIDTH_POW = WB_DATA_WIDTH_POW,
    parameter int unsigned REG_MEM_DEPTH_POW  = WB_RD_WIDTH,
    parameter int unsigned FIFO_DEPTH_POW     = WB_FIFO_DEPTH_POW
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 alu_valid_in,
    output logic                                 alu_ready_out,
    input  logic [REG_MEM_DEPTH_POW-1:0]         alu_rd_in,
    input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] alu_data_in,
    input  logic                                 lsu_valid_in,
    output logic                                 lsu_ready_out,
    input  logic [REG_MEM_DEPTH_POW-1:0]         lsu_rd_in,
    input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] lsu_data_in,
    input  logic                                 flush_in,
`ifdef WB_BYPASS_EN
    input  logic [REG_MEM_DEPTH_POW-1:0]         bypass_rs1_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]         bypass_rs2_in,
    output logic                                 bypass1_hit_out,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0] bypass1_data_out,
    output logic                                 bypass2_hit_out,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0] bypass2_data_out,
`endif
    output logic                                 write_en_out,
    output logic [REG_MEM_DEPTH_POW-1:0]         rd_out,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0] data_write_out
);

    localparam int unsigned REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
    localparam int unsigned ENTRY_W        = REG_MEM_DEPTH_POW + REG_DATA_WIDTH;

    logic               alu_full_c, alu_empty_c;
    logic               lsu_full_c, lsu_empty_c;
    logic [ENTRY_W-1:0] alu_head_c, lsu_head_c;
    logic [ENTRY_W-1:0] pop_entry_c;
    logic               grant_alu_c, grant_lsu_c;
    rr_src_e            rr_q, rr_d;

    wb_fifo #(.DEPTH_POW(FIFO_DEPTH_POW), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .flush_in     (flush_in),
        .push_in      (alu_valid_in),
        .push_data_in ({alu_rd_in, alu_data_in}),
        .pop_in       (grant_alu_c),
        .full_c       (alu_full_c),
        .empty_c      (alu_empty_c),
        .head_c       (alu_head_c)
    );

    wb_fifo #(.DEPTH_POW(FIFO_DEPTH_POW), .WIDTH(ENTRY_W)) u_lsu_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .flush_in     (flush_in),
        .push_in      (lsu_valid_in),
        .push_data_in ({lsu_rd_in, lsu_data_in}),
        .pop_in       (grant_lsu_c),
        .full_c       (lsu_full_c),
        .empty_c      (lsu_empty_c),
        .head_c       (lsu_head_c)
    );

    // Ready depends only on occupancy, never on valid
    assign alu_ready_out = !alu_full_c;
    assign lsu_ready_out = !lsu_full_c;

    // Round-robin pointer register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) rr_q <= RR_ALU;
        else           rr_q <= rr_d;
    end

    // Grant selection; pointer moves to the source not granted, flush freezes it
    always_comb begin
        grant_alu_c = 1'b0;
        grant_lsu_c = 1'b0;
        rr_d        = rr_q;
        if (!flush_in) begin
            if (!alu_empty_c && (lsu_empty_c || rr_q == RR_ALU)) begin
                grant_alu_c = 1'b1;
                rr_d        = RR_LSU;
            end else if (!lsu_empty_c) begin
                grant_lsu_c = 1'b1;
                rr_d        = RR_ALU;
            end
        end
    end

    assign pop_entry_c = grant_alu_c ? alu_head_c : lsu_head_c;

    // Registered write port; rd 0 is drained without a strobe
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_in) begin
            write_en_out   <= 1'b0;
            rd_out         <= '0;
            data_write_out <= '0;
        end else begin
            write_en_out <= (grant_alu_c || grant_lsu_c) &&
                            (pop_entry_c[ENTRY_W-1 -: REG_MEM_DEPTH_POW] != '0);
            if (grant_alu_c || grant_lsu_c) begin
                rd_out         <= pop_entry_c[ENTRY_W-1 -: REG_MEM_DEPTH_POW];
                data_write_out <= pop_entry_c[REG_DATA_WIDTH-1:0];
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to matching source operands
    always_comb begin
        bypass1_hit_out  = write_en_out && (rd_out == bypass_rs1_in);
        bypass2_hit_out  = write_en_out && (rd_out == bypass_rs2_in);
        bypass1_data_out = bypass1_hit_out ? data_write_out : '0;
        bypass2_data_out = bypass2_hit_out ? data_write_out : '0;
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (optionally with WB_BYPASS_EN defined).
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     alu_valid_in, alu_ready_out;
    logic [WB_RD_WIDTH-1:0]   alu_rd_in;
    logic [WB_DATA_WIDTH-1:0] alu_data_in;
    logic                     lsu_valid_in, lsu_ready_out;
    logic [WB_RD_WIDTH-1:0]   lsu_rd_in;
    logic [WB_DATA_WIDTH-1:0] lsu_data_in;
    logic                     flush_in;
    logic                     write_en_out;
    logic [WB_RD_WIDTH-1:0]   rd_out;
    logic [WB_DATA_WIDTH-1:0] data_write_out;
`ifdef WB_BYPASS_EN
    logic [WB_RD_WIDTH-1:0]   bypass_rs1_in, bypass_rs2_in;
    logic                     bypass1_hit_out, bypass2_hit_out;
    logic [WB_DATA_WIDTH-1:0] bypass1_data_out, bypass2_data_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    writeback_arbiter dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_rd_in      (alu_rd_in),
        .alu_data_in    (alu_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_in      (lsu_rd_in),
        .lsu_data_in    (lsu_data_in),
        .flush_in       (flush_in),
`ifdef WB_BYPASS_EN
        .bypass_rs1_in    (bypass_rs1_in),
        .bypass_rs2_in    (bypass_rs2_in),
        .bypass1_hit_out  (bypass1_hit_out),
        .bypass1_data_out (bypass1_data_out),
        .bypass2_hit_out  (bypass2_hit_out),
        .bypass2_data_out (bypass2_data_out),
`endif
        .write_en_out   (write_en_out),
        .rd_out         (rd_out),
        .data_write_out (data_write_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic av, input wb_entry_t ae, input logic lv, input wb_entry_t le);
        alu_valid_in = av;
        alu_rd_in    = ae.rd;
        alu_data_in  = ae.data;
        lsu_valid_in = lv;
        lsu_rd_in    = le.rd;
        lsu_data_in  = le.data;
    endtask

    task automatic idle();
        wb_entry_t z;
        z = '0;
        drive(1'b0, z, 1'b0, z);
        flush_in = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
    endtask

    function automatic wb_entry_t ent(input int unsigned rd, input logic [63:0] data);
        wb_entry_t e;
        e.rd   = WB_RD_WIDTH'(rd);
        e.data = data;
        return e;
    endfunction

    wb_entry_t none_e;
    int a_idx, l_idx, n_alu_wr, n_lsu_wr;
    logic a_acc, l_acc;
    logic [WB_RD_WIDTH-1:0] alu_wr [3];
    logic [WB_RD_WIDTH-1:0] last_lsu_rd;
    logic ready_at2;

    initial begin
        none_e = '0;
`ifdef WB_BYPASS_EN
        bypass_rs1_in = '0;
        bypass_rs2_in = '0;
`endif
        // Reset state
        idle();
        rst_n_in = 1'b0;
        tick();
        tick();
        check_eq("rst_we", 64'(write_en_out), 64'd0);
        check_eq("rst_rd", 64'(rd_out), 64'd0);
        check_eq("rst_data", data_write_out, 64'd0);
        rst_n_in = 1'b1;
        check_eq("rst_alu_ready", 64'(alu_ready_out), 64'd1);
        check_eq("rst_lsu_ready", 64'(lsu_ready_out), 64'd1);

        // Single ALU push: strobe two edges after drive
        drive(1'b1, ent(5, 64'hDEAD), 1'b0, none_e);
        tick();
        check_eq("single_we_early", 64'(write_en_out), 64'd0);
        idle();
        tick();
        check_eq("single_we", 64'(write_en_out), 64'd1);
        check_eq("single_rd", 64'(rd_out), 64'd5);
        check_eq("single_data", data_write_out, 64'hDEAD);
        tick();
        check_eq("single_we_after", 64'(write_en_out), 64'd0);

        // Simultaneous push from reset: ALU first, then LSU
        reset_dut();
        drive(1'b1, ent(1, 64'h11), 1'b1, ent(2, 64'h22));
        tick();
        idle();
        tick();
        check_eq("both_first_we", 64'(write_en_out), 64'd1);
        check_eq("both_first_rd", 64'(rd_out), 64'd1);
        tick();
        check_eq("both_second_we", 64'(write_en_out), 64'd1);
        check_eq("both_second_rd", 64'(rd_out), 64'd2);
        check_eq("both_second_data", data_write_out, 64'h22);
        tick();
        check_eq("both_idle_we", 64'(write_en_out), 64'd0);

        // Three ALU pushes against continuous LSU traffic
        reset_dut();
        a_idx = 0; l_idx = 0; n_alu_wr = 0; n_lsu_wr = 0;
        last_lsu_rd = '0; ready_at2 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            drive(a_idx < 3, ent(a_idx + 1, 64'(a_idx + 100)),
                  l_idx < 8, ent(16 + l_idx, 64'(l_idx + 200)));
            a_acc = alu_valid_in && alu_ready_out;
            l_acc = lsu_valid_in && lsu_ready_out;
            tick();
            if (a_acc) a_idx++;
            if (l_acc) l_idx++;
            if (c == 2) ready_at2 = alu_ready_out;
            if (write_en_out) begin
                if (rd_out < 16) begin
                    if (n_alu_wr < 3) alu_wr[n_alu_wr] = rd_out;
                    n_alu_wr++;
                end else begin
                    n_lsu_wr++;
                    last_lsu_rd = rd_out;
                end
            end
        end
        idle();
        check_eq("rr_alu_ready_full", 64'(ready_at2), 64'd0);
        check_eq("rr_alu_count", 64'(n_alu_wr), 64'd3);
        check_eq("rr_alu_order0", 64'(alu_wr[0]), 64'd1);
        check_eq("rr_alu_order1", 64'(alu_wr[1]), 64'd2);
        check_eq("rr_alu_order2", 64'(alu_wr[2]), 64'd3);
        check_eq("rr_lsu_count", 64'(n_lsu_wr), 64'd8);
        check_eq("rr_lsu_last", 64'(last_lsu_rd), 64'd23);

        // rd 0 drained silently, following entry still written
        reset_dut();
        drive(1'b0, none_e, 1'b1, ent(0, 64'h55));
        tick();
        check_eq("rd0_we_a", 64'(write_en_out), 64'd0);
        drive(1'b0, none_e, 1'b1, ent(9, 64'h99));
        tick();
        check_eq("rd0_we_b", 64'(write_en_out), 64'd0);
        idle();
        tick();
        check_eq("rd0_next_we", 64'(write_en_out), 64'd1);
        check_eq("rd0_next_rd", 64'(rd_out), 64'd9);
        check_eq("rd0_next_data", data_write_out, 64'h99);

        // Flush with two entries buffered; pointer must survive the flush
        reset_dut();
        drive(1'b1, ent(3, 64'h33), 1'b0, none_e);
        tick();
        drive(1'b1, ent(4, 64'h44), 1'b1, ent(5, 64'h55));
        tick();
        check_eq("fl_pre_rd", 64'(rd_out), 64'd3);
        drive(1'b1, ent(11, 64'hBB), 1'b0, none_e);
        flush_in = 1'b1;
        tick();
        check_eq("fl_we", 64'(write_en_out), 64'd0);
        check_eq("fl_rd", 64'(rd_out), 64'd0);
        idle();
        tick();
        check_eq("fl_after_we", 64'(write_en_out), 64'd0);
        check_eq("fl_alu_ready", 64'(alu_ready_out), 64'd1);
        drive(1'b1, ent(1, 64'h1), 1'b1, ent(2, 64'h2));
        tick();
        check_eq("fl_push_we", 64'(write_en_out), 64'd0);
        idle();
        tick();
        check_eq("fl_rr_first", 64'(rd_out), 64'd2);
        check_eq("fl_rr_first_we", 64'(write_en_out), 64'd1);
        tick();
        check_eq("fl_rr_second", 64'(rd_out), 64'd1);
        tick();
        check_eq("fl_drained_we", 64'(write_en_out), 64'd0);

        // Reset mid-stream discards in-flight entries
        drive(1'b1, ent(4, 64'h4), 1'b1, ent(6, 64'h6));
        tick();
        idle();
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        check_eq("mid_rst_we", 64'(write_en_out), 64'd0);
        check_eq("mid_rst_alu_ready", 64'(alu_ready_out), 64'd1);
        check_eq("mid_rst_lsu_ready", 64'(lsu_ready_out), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("mid_rst_quiet", 64'(write_en_out), 64'd0);
        end

`ifdef WB_BYPASS_EN
        // Forwarding of the write in flight
        reset_dut();
        bypass_rs1_in = 5'd7;
        bypass_rs2_in = 5'd8;
        drive(1'b1, ent(7, 64'h42), 1'b0, none_e);
        tick();
        check_eq("byp_miss_hit", 64'(bypass1_hit_out), 64'd0);
        idle();
        tick();
        check_eq("byp1_hit", 64'(bypass1_hit_out), 64'd1);
        check_eq("byp1_data", bypass1_data_out, 64'h42);
        check_eq("byp2_hit", 64'(bypass2_hit_out), 64'd0);
        check_eq("byp2_data", bypass2_data_out, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
